// File: rtl/stream_xor_stage.sv
// Stream XOR stage: XORs each accepted byte with the external keystream generator
// output, re-seeding the generator once per length-delimited frame.
module stream_xor_stage #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       seed,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             prng_load,
    output logic [7:0]       prng_seed,
    output logic             prng_step,
    input  logic [7:0]       prng_value,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t           state_q;
    logic [7:0]       seed_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count_q;
    logic             out_valid_q;
    logic [7:0]       out_data_q;
    logic             out_last_q;
    logic             done_q;

    logic accept;
    logic last_byte;
    logic abort_act;

    assign abort_act = abort && (state_q != IDLE);

    // in_ready never looks at in_valid or abort; abort only gates the internal accept.
    assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready && !abort;
    assign last_byte = (count_q == (len_q - LEN_W'(1)));

    assign prng_load = (state_q == LOAD);
    assign prng_seed = seed_q;
    assign prng_step = accept;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            seed_q      <= 8'h00;
            len_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_act) begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                count_q     <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && (frame_len != '0)) begin
                            seed_q  <= seed;
                            len_q   <= frame_len;
                            count_q <= '0;
                            state_q <= LOAD;
                        end
                    end
                    LOAD: begin
                        state_q <= RUN;
                    end
                    RUN: begin
                        if (accept) begin
                            out_data_q  <= in_data ^ prng_value;
                            out_valid_q <= 1'b1;
                            out_last_q  <= last_byte;
                            count_q     <= count_q + LEN_W'(1);
                            if (last_byte) begin
                                state_q <= FLUSH;
                            end
                        end else if (out_ready) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end
                    end
                    FLUSH: begin
                        // The final byte is still in the output register; done follows its handshake.
                        if (out_valid_q && out_ready) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stream_xor_stage.sv
// Directed bench for stream_xor_stage with an 8-bit Galois LFSR standing in for the
// keystream generator and a per-byte keystream model computed from the frame seed.
module tb_stream_xor_stage;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       seed = 8'h00;
    logic [LEN_W-1:0] frame_len = '0;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_last;
    logic             out_ready = 1'b1;
    logic             prng_load;
    logic [7:0]       prng_seed;
    logic             prng_step;
    logic [7:0]       prng_value;
    logic             busy;
    logic             done;

    stream_xor_stage #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seed       (seed),
        .frame_len  (frame_len),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .prng_load  (prng_load),
        .prng_seed  (prng_seed),
        .prng_step  (prng_step),
        .prng_value (prng_value),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int step_cnt = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] cap[$];

    logic [7:0] f_seed;
    int         f_len;
    int         f_idx;

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
    endfunction

    // k-th keystream byte after the seed (k = 0 is the seed itself).
    function automatic logic [7:0] ks_at(input logic [7:0] s, input int k);
        logic [7:0] v = s;
        for (int i = 0; i < k; i++) v = lfsr_next(v);
        return v;
    endfunction

    logic [7:0] ks_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         ks_q <= 8'h00;
        else if (prng_load) ks_q <= prng_seed;
        else if (prng_step) ks_q <= lfsr_next(ks_q);
    end
    assign prng_value = ks_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output scoreboard and protocol monitor, evaluated mid-cycle before the next edge.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %0h, expected none at %0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                end
                cap.push_back(out_data);
            end
            if (prng_step) step_cnt++;
            if (done) done_cnt++;
            check("step_without_accept", prng_step && !(in_valid && in_ready), 0);
            check("load_and_step", prng_load && prng_step, 0);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_prng_load"}, prng_load, 0);
        check({tag, "_prng_step"}, prng_step, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic start_frame(input logic [7:0] s, input int len);
        start = 1'b1;
        seed = s;
        frame_len = LEN_W'(len);
        f_seed = s;
        f_len = len;
        f_idx = 0;
        @(negedge clk);
        start = 1'b0;
        seed = ~s;
        frame_len = LEN_W'(len + 7);
        check("prng_load_cycle1", prng_load, 1);
        check("prng_seed", prng_seed, s);
        @(negedge clk);
        check("prng_load_once", prng_load, 0);
    endtask

    task automatic send_byte(input logic [7:0] d);
        bit ok = 0;
        in_valid = 1'b1;
        in_data = d;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (in_ready) ok = 1;
            @(negedge clk);
            if (ok) break;
        end
        in_valid = 1'b0;
        if (!ok) begin
            check("in_ready_timeout", 0, 1);
        end else begin
            exp_q.push_back({d ^ ks_at(f_seed, f_idx), (f_idx == f_len - 1)});
            f_idx++;
        end
    endtask

    task automatic finish_frame(input int exp_done_total);
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check("done_seen", done, 1);
        check("busy_with_done", busy, 0);
        @(negedge clk);
        check("done_single", done, 0);
        check("done_count", done_cnt, exp_done_total);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] plain [8];
        logic [7:0] ct [8];
        logic [7:0] od;
        logic [7:0] pv;
        int st;
        int dsave;

        plain[0] = 8'h48; plain[1] = 8'h65; plain[2] = 8'h6C; plain[3] = 8'h6C;
        plain[4] = 8'h6F; plain[5] = 8'h21; plain[6] = 8'h00; plain[7] = 8'hFF;

        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte, seed A5
        cap.delete();
        st = step_cnt;
        start_frame(8'hA5, 1);
        send_byte(8'h00);
        finish_frame(1);
        check("a5_steps", step_cnt - st, 1);
        check("a5_size", cap.size(), 1);
        if (cap.size() > 0) check("a5_literal", cap[0], 8'hA5);

        // Four bytes back-to-back, seed EE: keystream EE 77 83 F9
        cap.delete();
        st = step_cnt;
        start_frame(8'hEE, 4);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        finish_frame(2);
        check("ee_steps", step_cnt - st, 4);
        check("ee_size", cap.size(), 4);
        if (cap.size() == 4) begin
            check("ee_lit0", cap[0], 8'hFF);
            check("ee_lit1", cap[1], 8'h55);
            check("ee_lit2", cap[2], 8'hB0);
            check("ee_lit3", cap[3], 8'hBD);
        end

        // Backpressure for 3 cycles with a pending input and a start attempt mid-frame
        st = step_cnt;
        start_frame(8'h5A, 4);
        send_byte(8'h01);
        send_byte(8'h02);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h03;
        start = 1'b1;
        seed = 8'h00;
        frame_len = LEN_W'(1);
        od = out_data;
        pv = ks_q;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_out_data", out_data, od);
            check("bp_prng_value", ks_q, pv);
            check("bp_out_valid", out_valid, 1);
            check("bp_busy", busy, 1);
            check("bp_no_reload", prng_load, 0);
            @(negedge clk);
            start = 1'b0;
        end
        check("bp_no_step", step_cnt - st, 2);
        out_ready = 1'b1;
        send_byte(8'h03);
        send_byte(8'h04);
        finish_frame(3);
        check("bp_steps", step_cnt - st, 4);

        // Round trip, seed 3C
        cap.delete();
        start_frame(8'h3C, 8);
        for (int i = 0; i < 8; i++) send_byte(plain[i]);
        finish_frame(4);
        check("rt_enc_size", cap.size(), 8);
        for (int i = 0; i < 8; i++) ct[i] = (i < cap.size()) ? cap[i] : 8'h00;
        cap.delete();
        start_frame(8'h3C, 8);
        for (int i = 0; i < 8; i++) send_byte(ct[i]);
        finish_frame(5);
        check("rt_dec_size", cap.size(), 8);
        for (int i = 0; i < 8 && i < cap.size(); i++) check("rt_plain", cap[i], plain[i]);

        // Abort after 2 of 5 bytes; the second byte is discarded unacknowledged
        st = step_cnt;
        dsave = done_cnt;
        start_frame(8'h99, 5);
        send_byte(8'hC1);
        send_byte(8'hC2);
        out_ready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_last", out_last, 0);
        check("abort_steps", step_cnt - st, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_busy", busy, 0);
        @(negedge clk);
        check("abort_no_done", done_cnt, dsave);
        cap.delete();
        start_frame(8'hA5, 1);
        send_byte(8'h00);
        finish_frame(6);
        check("post_abort_size", cap.size(), 1);
        if (cap.size() > 0) check("post_abort_lit", cap[0], 8'hA5);

        // frame_len = 0 leaves IDLE untouched
        start = 1'b1;
        seed = 8'h12;
        frame_len = '0;
        @(negedge clk);
        start = 1'b0;
        check("len0_busy", busy, 0);
        check("len0_load", prng_load, 0);
        @(negedge clk);
        check("len0_busy2", busy, 0);
        check("len0_load2", prng_load, 0);

        // Asynchronous reset mid-frame
        start_frame(8'h77, 3);
        send_byte(8'h10);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cap.delete();
        start_frame(8'hA5, 1);
        send_byte(8'h00);
        finish_frame(7);
        check("post_rst_size", cap.size(), 1);
        if (cap.size() > 0) check("post_rst_lit", cap[0], 8'hA5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stream_xor_stage.md
# stream_xor_stage

Downstream consumer of the 8-bit keystream generator. It accepts plaintext (or ciphertext) bytes over a valid/ready stream and XORs each byte with the current keystream byte. It drives the generator's seed-load and step controls so that exactly one keystream step occurs per accepted byte. Frames are length-delimited, and each frame re-seeds the generator, so encryption and decryption are the same operation.

## Interface
- LEN_W, 16, width of frame length and byte counter
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin frame (sampled only in IDLE)
- seed  input  8  frame seed, sampled with start
- frame_len  input  LEN_W  bytes in frame; 0 means start is ignored
- abort  input  1  synchronous frame abort
- in_valid  input  1  input byte valid
- in_data  input  8  input byte
- in_ready  output  1  stage accepts in_data this cycle
- out_valid  output  1  output byte valid
- out_data  output  8  in_data XOR keystream
- out_last  output  1  marks final byte of frame
- out_ready  input  1  downstream accepts out_data
- prng_load  output  1  to generator load_seed
- prng_seed  output  8  to generator seed_in
- prng_step  output  1  to generator encrypt_en
- prng_value  input  8  generator's registered output
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse when the last byte leaves

## Operation
- States: IDLE, LOAD, RUN, FLUSH.
- IDLE
  - start && frame_len != 0: latch seed into seed_q and frame_len into len_q, clear count, go to LOAD.
  - Any other condition: stay in IDLE.
- LOAD
  - prng_load = 1 and prng_seed = seed_q for exactly one cycle; next state RUN.
  - The generator holds seed_q from the following cycle.
- RUN
  - in_ready = !out_valid || out_ready (single output register, full throughput).
  - Accept = in_valid && in_ready.
  - On accept:
    - out_data <= in_data ^ prng_value
    - out_valid <= 1
    - out_last <= (count == len_q-1)
    - prng_step = 1 (combinational, same cycle)
    - count <= count+1
  - When the accepted byte is the last one, go to FLUSH.
- FLUSH
  - in_ready = 0.
  - On out_valid && out_ready: clear out_valid and out_last, pulse done, go to IDLE.
- Output register
  - With no new accept, out_valid clears on out_ready.
  - With out_valid && !out_ready, out_data, out_valid and out_last hold stable.
- prng_seed outputs seed_q at all times; it is only meaningful while prng_load is high.
- prng_step is never high outside RUN and never high without an accept. prng_load and prng_step are never both high.
- abort (any state except IDLE):
  - next cycle state = IDLE; out_valid, out_last and count are cleared.
  - No done pulse; prng_step = 0 in the abort cycle.
  - abort in IDLE has no effect.
- start outside IDLE is ignored. seed and frame_len changes after latching have no effect.
- count width is LEN_W. The maximum frame is 2^LEN_W-1 bytes; count never wraps within a frame.

## Timing
- Reset values:
  - State IDLE, count = 0, seed_q = 0, len_q = 0.
  - in_ready, out_valid, out_data, out_last, prng_load, prng_step, busy and done are all 0.
- Startup: start in cycle 0 → LOAD in cycle 1 (prng_load high) → RUN in cycle 2, where in_ready may first be 1.
- Keystream alignment:
  - Byte k of a frame (k from 0) is XORed with the k-th generator state after the seed.
  - Byte 0 uses the seed itself.
- Latency: in_data to out_data is 1 cycle.
- Sustained throughput is 1 byte/cycle while out_ready = 1.
- done rises in the cycle after the final output handshake. busy falls in the same cycle.
- Back-to-back frames: start is accepted in the cycle done is high, because the state is IDLE in that cycle.
- in_ready is combinational from out_valid, out_ready and state; there is no combinational path from in_valid.

## Test plan
- Seed 0xA5, frame_len 1, in_data 0x00, out_ready tied 1:
  - prng_load is high in cycle 1.
  - out_data = 0xA5 with out_last = 1.
  - done pulses once, and prng_step pulses exactly once.
- Seed 0xEE, frame_len 4, bytes 0x11, 0x22, 0x33, 0x44 streamed back-to-back:
  - Outputs equal each byte XORed with a generator reference model, sequence 0xEE, …
  - out_last only on the 4th output; 4 steps total.
- Backpressure: hold out_ready = 0 for 3 cycles mid-frame.
  - in_ready drops, and out_data and prng_value stay stable.
  - No extra prng_step; data continues correctly when out_ready returns.
- Round trip:
  - Encrypt 8 bytes with seed 0x3C.
  - Feed the ciphertext back with the same seed; plaintext is recovered exactly.
- Abort after 2 of 5 bytes:
  - busy = 0 next cycle, out_valid = 0, no done.
  - A new start with seed 0xA5 and len 1 yields 0xA5 for input 0x00.
- Edge cases:
  - start with frame_len = 0 leaves IDLE unchanged.
  - start during RUN is ignored.
  - rst_n asserted mid-frame returns all outputs to their reset values immediately.
